// File: rtl/fabric_out_arbiter_pkg.sv
// fabric_out_arbiter_pkg: shared fabric port defaults and source-index width helper
package fabric_out_arbiter_pkg;
  localparam int NUM_IN_DEF = 4;
  localparam int WIDTH_DEF = 16;
  function automatic int src_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fabric_out_arbiter_if.sv
// fabric_out_arbiter_if: source-side and downstream-side handshake bundle of one output port
interface fabric_out_arbiter_if import fabric_out_arbiter_pkg::*; #(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  localparam int SRC_W = src_w(NUM_IN);
  logic [NUM_IN*WIDTH-1:0] i_data_in;
  logic [NUM_IN-1:0] i_valid_in;
  logic [NUM_IN-1:0] i_ready_out;
  logic [NUM_IN-1:0] i_mask;
  logic [WIDTH-1:0] o_data_out;
  logic [SRC_W-1:0] o_src_out;
  logic o_valid_out;
  logic o_ready_in;
  modport master(
    input i_data_in, i_valid_in, i_mask, o_ready_in,
    output i_ready_out, o_data_out, o_src_out, o_valid_out
  );
  modport slave(
    output i_data_in, i_valid_in, i_mask, o_ready_in,
    input i_ready_out, o_data_out, o_src_out, o_valid_out
  );
endinterface

// File: rtl/fabric_out_arbiter_rr_select.sv
// rr_select: first set request bit at or above ptr, wrapping modulo N
module rr_select import fabric_out_arbiter_pkg::*; #(
  parameter int N = NUM_IN_DEF,
  localparam int W = src_w(N)
) (
  input logic [N-1:0] req_i,
  input logic [W-1:0] ptr_i,
  output logic [W-1:0] win_o,
  output logic any_o
);
  // scan from farthest to nearest offset so the nearest request overwrites
  always_comb begin
    win_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % N]) win_o = W'((int'(ptr_i) + i) % N);
  end
  assign any_o = |req_i;
endmodule

// File: rtl/fabric_out_arbiter.sv
// fabric_out_arbiter: round-robin merge of NUM_IN masked sources into one registered output slot
module fabric_out_arbiter import fabric_out_arbiter_pkg::*; #(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst_n,
  fabric_out_arbiter_if.master bus
);
  localparam int SRC_W = src_w(NUM_IN);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0] state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SRC_W-1:0] src_q, src_d, ptr_q, ptr_d, win;
  logic [NUM_IN-1:0] req;
  logic any, load_ok, load;
  assign req = bus.i_valid_in & bus.i_mask;
  rr_select #(.N(NUM_IN)) u_sel (.req_i(req), .ptr_i(ptr_q), .win_o(win), .any_o(any));
  // grants are suppressed while reset is asserted even though the slot reads empty
  always_comb begin
    load_ok = (state_q == EMPTY) || bus.o_ready_in;
    load = rst_n && load_ok && any;
    state_d = load ? FULL : (bus.o_ready_in ? EMPTY : state_q);
    data_d = load ? bus.i_data_in[win*WIDTH +: WIDTH] : data_q;
    src_d = load ? win : src_q;
    ptr_d = load ? ((win == SRC_W'(NUM_IN - 1)) ? '0 : win + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      src_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.i_ready_out = load ? (NUM_IN'(1) << win) : '0;
  assign bus.o_data_out = data_q;
  assign bus.o_src_out = src_q;
  assign bus.o_valid_out = (state_q == FULL);
endmodule

// File: doc/fabric_out_arbiter.md
FABRIC_OUT_ARBITER -- requirements
Module: fabric_out_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of packet sources (demux outputs) sharing one output port; legal range 2..8.
REQ-002 Parameter WIDTH, default 16, packet width in bits, equal to the demux WIDTH_OUT.
REQ-003 Localparam SRC_W = clog2(NUM_IN), source index width.
REQ-004 clk  input  1  single clock for the whole block.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_data_in  input  NUM_IN*WIDTH  packet from source k in bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-007 i_valid_in  input  NUM_IN  source k holds a valid packet.
REQ-008 i_ready_out  output  NUM_IN  source k's packet is taken this cycle (one-hot or zero).
REQ-009 i_mask  input  NUM_IN  per-source enable; 0 excludes that source from arbitration.
REQ-010 o_data_out  output  WIDTH  registered packet to the downstream port.
REQ-011 o_src_out  output  SRC_W  index of the source that supplied o_data_out.
REQ-012 o_valid_out  output  1  o_data_out/o_src_out valid.
REQ-013 o_ready_in  input  1  downstream accepts o_data_out this cycle.

Function
REQ-014 Transfer on the output side occurs in a cycle where o_valid_out=1 and o_ready_in=1.
REQ-015 Load slot open: load_ok = ~o_valid_out | o_ready_in (output register empty or draining this cycle).
REQ-016 Eligible set: req = i_valid_in & i_mask.
REQ-017 Winner: first set bit of req scanning from rr_ptr upward, wrapping modulo NUM_IN; none if req=0.
REQ-018 i_ready_out[k] = load_ok & (winner==k) & (req!=0); combinational, all-zero otherwise.
REQ-019 On a load, the winner's packet and index register into o_data_out/o_src_out, o_valid_out=1 next cycle; latency exactly 1 cycle from input handshake to o_valid_out.
REQ-020 On a load, rr_ptr <= (winner+1) mod NUM_IN; without a load rr_ptr holds.
REQ-021 Output transfer without a load: o_valid_out <= 0 next cycle.
REQ-022 Simultaneous transfer and load: the new packet replaces the old one; sustained throughput one packet per cycle.
REQ-023 o_ready_in=0 with o_valid_out=1: o_data_out, o_src_out, o_valid_out hold stable; all i_ready_out=0.
REQ-024 i_mask changes take effect in the same cycle; a packet already in the output register is unaffected.
REQ-025 Sources with i_valid_in=1 and i_mask=0 are never granted and do not move rr_ptr.
REQ-026 Fairness: with all NUM_IN sources continuously eligible and o_ready_in=1, grants cycle 0,1,...,NUM_IN-1,0,...; no source waits more than NUM_IN-1 loads.
REQ-027 State machine per output slot: EMPTY (o_valid_out=0) -> FULL on load; FULL -> EMPTY on transfer without load; FULL -> FULL on stall or transfer-with-load.
REQ-028 Free-running counter o_pkt_cnt is not provided; statistics are out of scope.

Reset
REQ-029 rst_n=0 asynchronously forces o_valid_out=0, o_src_out=0, o_data_out=0, rr_ptr=0.
REQ-030 i_ready_out is 0 while rst_n=0 regardless of inputs.
REQ-031 Reset mid-packet discards the output register contents; no partial packet is re-emitted after reset release.
REQ-032 First grant after reset release goes to the lowest-index eligible source.

Structure
REQ-033 NUM_IN default, WIDTH default and a clog2-style SRC_W helper live in the shared fabric_port package.
REQ-034 The round-robin priority selector is one sub-module, rr_select (req, ptr -> winner, any), reusable by other fabric port arbiters.
REQ-035 Output register and rr_ptr live in fabric_out_arbiter; no other storage.

Verification
REQ-036 Reset, then i_valid_in=4'b1111, i_mask=4'b1111, o_ready_in=1 for 8 cycles -> o_src_out sequence 0,1,2,3,0,1,2,3 starting 1 cycle after first grant.
REQ-037 Only source 2 valid with data 16'hA5A5, o_ready_in=1 for 3 cycles -> i_ready_out=4'b0100 each cycle, o_data_out=16'hA5A5 back-to-back, o_valid_out high 3 cycles.
REQ-038 Output FULL with 16'h1234, o_ready_in=0 for 5 cycles, sources valid -> data held at 16'h1234, i_ready_out=0; o_ready_in=1 -> next packet loads same cycle, no bubble.
REQ-039 i_valid_in=4'b1010, i_mask=4'b0010 -> only source 1 granted; source 3 never granted; rr_ptr moves to 2.
REQ-040 rst_n pulsed low while o_valid_out=1 -> o_valid_out=0 immediately (asynchronous); after release with i_valid_in=4'b1100 first grant is source 2.
REQ-041 rr_ptr=3, i_valid_in=4'b1001 -> source 3 granted, then source 0 (wrap-around), rr_ptr returns to 1.
